ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//   Ball physics engine for the 8x8 pong matrix. Produces the registered ball position pos_ball.
//   Consumes the paddle-hit flag `player` returned by the renderer/collision block, closing the loop.
//   Handles serve, diagonal motion, side-wall bounce, paddle return, miss detection and scoring.
//   Sits between the input/serve logic and the renderer; one instance per game.
// PARAMETERS
//   WIDTH         8      matrix size; ball x/y range 0..WIDTH-1
//   BIT_OF_WIDTH  3      bits per coordinate; pos_ball = {x,y}
//   TICK_DIV      25000  clk cycles per ball step (must be >= 4)
//   DIV_BITS      16     width of step divider counter
//   SCORE_BITS    4      width of each score counter
// PORTS
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 asynchronous, active-high reset
//   start      in   1                 serve request; sampled only in IDLE
//   player     in   2                 hit flag from collision logic: 01 top paddle, 10 down paddle, 00 none
//   pos_ball   out  2*BIT_OF_WIDTH    ball position {x[5:3], y[2:0]}
//   dir_x      out  1                 1 = x increasing, 0 = x decreasing
//   dir_y      out  1                 1 = moving down (y increasing), 0 = moving up
//   score_top  out  SCORE_BITS        points won by top player
//   score_down out  SCORE_BITS        points won by down player
//   point      out  2                 1-cycle pulse: 01 top scored, 10 down scored
//   state      out  2                 00 IDLE, 01 MOVE, 10 SCORED
// BEHAVIOUR
//   - Reset (async, immediate, any state): pos_ball = {3'd3,3'd3}, dir_x=1, dir_y=1,
//     scores=0, point=00, state=IDLE, divider=0.
//   - Divider: counts 0..TICK_DIV-1 only in MOVE and SCORED; step_en when count==TICK_DIV-1, then wraps to 0.
//     Divider is cleared on every state change.
//   - IDLE: ball held at (3,3); start=1 -> MOVE next edge. First step occurs TICK_DIV cycles later.
//   - MOVE, on step_en (all updates computed from pre-step values, applied on the same edge):
//       Y, up move (y==1, dir_y=0):
//         player[0]=1 -> y=2, dir_y=1
//         else        -> y=0, score_down+1, point=10, dir_y=0 (next serve to top), state SCORED
//       Y, down move (y==6, dir_y=1):
//         player[1]=1 -> y=5, dir_y=0
//         else        -> y=7, score_top+1, point=01, dir_y=1, state SCORED
//       Y, otherwise: y +/- 1 per dir_y.
//       X (ball columns limited to 1..6):
//         x==6, dir_x=1 -> x=5, dir_x=0
//         x==1, dir_x=0 -> x=2, dir_x=1
//         otherwise     -> x +/- 1
//       X and Y bounce independently; a corner step applies both.
//       On a miss, x still updates on that step.
//   - player sampled only on step_en; at other times ignored. Other player bit / value 11 = no hit for that row.
//   - SCORED: pos_ball frozen; after one full divider period (TICK_DIV cycles) -> IDLE.
//     On entry to IDLE: ball returns to (3,3) and dir_x=1; dir_y keeps the serve value set on the miss.
//   - point: asserted exactly the one cycle after the scoring edge, 00 otherwise.
//   - Scores saturate at 2^SCORE_BITS-1 (no wrap).
//   - start ignored in MOVE and SCORED.
//   - All outputs registered.
// TESTING (TICK_DIV=4)
//   1. Reset + serve, player=00:
//      rst pulse -> pos_ball=6'o33, state=00, scores 0.
//      start 1 cycle -> state=01; pos_ball (3,3)->(4,4)->(5,5)->(6,6) every 4 clk.
//   2. Corner step:
//      from (6,6), dir 1/1, player=10 at step -> (5,5), dir_x=0, dir_y=0, no point.
//   3. Miss at bottom, player=00 from (6,6):
//      -> y=7, score_top=1, point=01 for 1 cycle, state=10.
//      4 clk later -> IDLE, pos_ball=6'o33, dir_y=1.
//   4. Top miss:
//      ball at (2,1) moving up, player=10 (wrong row) -> treated as miss.
//      score_down+1, point=10, serve dir_y=0.
//   5. Misc:
//      start pulsed during MOVE -> no effect.
//      score_top preset to 15 via 15 misses, one more miss -> stays 15.
//   6. Async reset mid-MOVE:
//      rst asserted between edges -> outputs return to reset values without waiting for clk.
//      Divider restarts from 0 after start.

Source files
------------

// File: rtl/ball_motion.sv
// ball_motion - ball physics for the 8x8 pong matrix.
//   Serves the ball from the centre, moves it one diagonal step per divider
//   period, bounces it off the side walls, returns it on a paddle hit and
//   scores a point on a miss. All outputs are registered.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               serve request, honoured only in IDLE
//   player[1:0]         paddle hit flag from collision logic (01 top, 10 down)
//   pos_ball            ball position {x, y}
//   dir_x, dir_y        1 = coordinate increasing
//   score_top/down      saturating score counters
//   point[1:0]          one-cycle score pulse (01 top scored, 10 down scored)
//   state[1:0]          00 IDLE, 01 MOVE, 10 SCORED
module ball_motion #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int TICK_DIV     = 25000,
  parameter int DIV_BITS     = 16,
  parameter int SCORE_BITS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  player,
  output logic [2*BIT_OF_WIDTH-1:0]   pos_ball,
  output logic                        dir_x,
  output logic                        dir_y,
  output logic [SCORE_BITS-1:0]       score_top,
  output logic [SCORE_BITS-1:0]       score_down,
  output logic [1:0]                  point,
  output logic [1:0]                  state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVE   = 2'b01,
    ST_SCORED = 2'b10
  } state_e;

  localparam logic [BIT_OF_WIDTH-1:0] C_ONE  = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] C_LO   = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] C_HI   = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH-1:0] C_CTR  = BIT_OF_WIDTH'(WIDTH / 2 - 1);
  localparam logic [BIT_OF_WIDTH-1:0] C_TOP  = BIT_OF_WIDTH'(0);
  localparam logic [BIT_OF_WIDTH-1:0] C_BOT  = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [DIV_BITS-1:0]     DIV_LAST  = DIV_BITS'(TICK_DIV - 1);
  localparam logic [SCORE_BITS-1:0]   SCORE_MAX = '1;

  state_e                  state_q, state_d;
  logic [DIV_BITS-1:0]     div_q, div_d;
  logic [BIT_OF_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                    dx_q, dx_d, dy_q, dy_d;
  logic [SCORE_BITS-1:0]   top_q, top_d, down_q, down_d;
  logic [1:0]              point_q, point_d;
  logic                    step_en;

  // Only an exact 01 / 10 counts as a hit; 11 is treated as no hit.
  logic hit_top, hit_down;
  assign hit_top  = (player == 2'b01);
  assign hit_down = (player == 2'b10);

  assign step_en = (state_q != ST_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    top_d   = top_q;
    down_d  = down_q;
    point_d = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (step_en) begin
          // X: side walls bounce independently of Y, also on a missing step
          if (dx_q && x_q == C_HI) begin
            x_d  = x_q - C_ONE;
            dx_d = 1'b0;
          end else if (!dx_q && x_q == C_LO) begin
            x_d  = x_q + C_ONE;
            dx_d = 1'b1;
          end else if (dx_q) begin
            x_d = x_q + C_ONE;
          end else begin
            x_d = x_q - C_ONE;
          end

          if (!dy_q && y_q == C_LO) begin
            if (hit_top) begin
              y_d  = y_q + C_ONE;
              dy_d = 1'b1;
            end else begin
              // dir_y stays 0: the next serve heads towards the top row
              y_d     = C_TOP;
              point_d = 2'b10;
              state_d = ST_SCORED;
              if (down_q != SCORE_MAX) down_d = down_q + SCORE_BITS'(1);
            end
          end else if (dy_q && y_q == C_HI) begin
            if (hit_down) begin
              y_d  = y_q - C_ONE;
              dy_d = 1'b0;
            end else begin
              y_d     = C_BOT;
              point_d = 2'b01;
              state_d = ST_SCORED;
              if (top_q != SCORE_MAX) top_d = top_q + SCORE_BITS'(1);
            end
          end else if (dy_q) begin
            y_d = y_q + C_ONE;
          end else begin
            y_d = y_q - C_ONE;
          end
        end
      end
      ST_SCORED: begin
        if (step_en) begin
          state_d = ST_IDLE;
          x_d     = C_CTR;
          y_d     = C_CTR;
          dx_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Divider runs only while a ball is in play or a point is shown and
    // restarts on every state change.
    if (state_q == ST_IDLE || state_d != state_q || step_en) div_d = '0;
    else                                                      div_d = div_q + DIV_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      x_q     <= C_CTR;
      y_q     <= C_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      top_q   <= '0;
      down_q  <= '0;
      point_q <= 2'b00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      top_q   <= top_d;
      down_q  <= down_d;
      point_q <= point_d;
    end
  end

  assign pos_ball   = {x_q, y_q};
  assign dir_x      = dx_q;
  assign dir_y      = dy_q;
  assign score_top  = top_q;
  assign score_down = down_q;
  assign point      = point_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion - directed game scenarios followed by random play, every
//   cycle compared against a behavioural model of the ball game.
// Ports: none (top-level bench).
module tb_ball_motion;
  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] player = 2'b00;
  logic [5:0] pos_ball;
  logic       dir_x, dir_y;
  logic [3:0] score_top, score_down;
  logic [1:0] point, state;

  ball_motion #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .start(start), .player(player),
    .pos_ball(pos_ball), .dir_x(dir_x), .dir_y(dir_y),
    .score_top(score_top), .score_down(score_down),
    .point(point), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural game model: mode 0 idle, 1 ball in play, 2 point shown.
  int mx, my, mdx, mdy, mode, ticks, mtop, mdown, mpt;

  task automatic model_reset();
    mx = 3; my = 3; mdx = 1; mdy = 1; mode = 0; ticks = 0;
    mtop = 0; mdown = 0; mpt = 0;
  endtask

  task automatic ball_step(input logic [1:0] p);
    int nx, ndx;
    ndx = mdx;
    if (mdx == 1 && mx == 6)      begin nx = 5; ndx = 0; end
    else if (mdx == 0 && mx == 1) begin nx = 2; ndx = 1; end
    else                          nx = mx + (mdx == 1 ? 1 : -1);
    if (mdy == 0 && my == 1) begin
      if (p == 2'b01) begin my = 2; mdy = 1; end
      else begin
        my = 0; mdy = 0; mpt = 2; mode = 2;
        if (mdown < 15) mdown++;
      end
    end else if (mdy == 1 && my == 6) begin
      if (p == 2'b10) begin my = 5; mdy = 0; end
      else begin
        my = 7; mdy = 1; mpt = 1; mode = 2;
        if (mtop < 15) mtop++;
      end
    end else begin
      my = my + (mdy == 1 ? 1 : -1);
    end
    mx = nx; mdx = ndx;
  endtask

  task automatic model_edge(input logic s, input logic [1:0] p);
    mpt = 0;
    if (mode == 0) begin
      if (s) begin mode = 1; ticks = 0; end
    end else begin
      ticks++;
      if (ticks == TICK) begin
        ticks = 0;
        if (mode == 1) ball_step(p);
        else begin mode = 0; mx = 3; my = 3; mdx = 1; end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    return {12'd0, 3'(mx), 3'(my), 1'(mdx), 1'(mdy), 4'(mtop), 4'(mdown), 2'(mpt), 2'(mode)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {12'd0, pos_ball, dir_x, dir_y, score_top, score_down, point, state};
  endfunction

  task automatic cyc(input logic s, input logic [1:0] p);
    @(negedge clk);
    start = s; player = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic step_period(input logic [1:0] p);
    for (int i = 0; i < TICK; i++) cyc(1'b0, p);
  endtask

  // Play from IDLE (optionally serving) until the point ends; top paddle
  // always returns, bottom paddle always misses.
  task automatic rally(input bit serve);
    int k;
    if (serve) cyc(1'b1, 2'b00);
    k = 0;
    while (mode != 0 && k < 400) begin
      cyc(1'b0, (my == 1 && mdy == 0) ? 2'b01 : 2'b00);
      k++;
    end
    chk("rally_end_idle", 32'(state), 32'd0);
  endtask

  logic [1:0] rp;
  int r;

  initial begin
    model_reset();
    #12;
    chk("rst_pos", 32'(pos_ball), 32'o33);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_scores", 32'({score_top, score_down}), 32'd0);
    chk("rst_dirs", 32'({dir_x, dir_y}), 32'd3);
    chk("rst_point", 32'(point), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // serve and straight diagonal run
    cyc(1'b1, 2'b00);
    chk("serve_state", 32'(state), 32'd1);
    step_period(2'b00); chk("serve_44", 32'(pos_ball), 32'o44);
    step_period(2'b00); chk("serve_55", 32'(pos_ball), 32'o55);
    step_period(2'b00); chk("serve_66", 32'(pos_ball), 32'o66);

    // corner step with bottom paddle hit
    step_period(2'b10);
    chk("corner_pos", 32'(pos_ball), 32'o55);
    chk("corner_dirs", 32'({dir_x, dir_y}), 32'd0);
    chk("corner_nopoint", 32'(point), 32'd0);
    for (int i = 0; i < 4; i++) step_period(2'b00);
    chk("reach_11", 32'(pos_ball), 32'o11);
    step_period(2'b01);
    chk("top_hit_pos", 32'(pos_ball), 32'o22);
    chk("top_hit_dirs", 32'({dir_x, dir_y}), 32'd3);
    for (int i = 0; i < 4; i++) step_period(2'b00);

    // bottom miss
    step_period(2'b00);
    chk("bmiss_pos", 32'(pos_ball), 32'o57);
    chk("bmiss_point", 32'(point), 32'd1);
    chk("bmiss_score", 32'(score_top), 32'd1);
    chk("bmiss_state", 32'(state), 32'd2);
    cyc(1'b0, 2'b00);
    chk("bmiss_pulse_end", 32'(point), 32'd0);
    for (int i = 0; i < TICK - 1; i++) cyc(1'b1, 2'b00);
    chk("bmiss_idle", 32'(state), 32'd0);
    chk("bmiss_center", 32'(pos_ball), 32'o33);
    chk("bmiss_serve_dir", 32'(dir_y), 32'd1);

    // top miss with wrong-row hit flag
    cyc(1'b1, 2'b00);
    for (int i = 0; i < 3; i++) step_period(2'b00);
    step_period(2'b10);
    for (int i = 0; i < 4; i++) step_period(2'b00);
    chk("reach_11b", 32'(pos_ball), 32'o11);
    step_period(2'b10);
    chk("tmiss_point", 32'(point), 32'd2);
    chk("tmiss_score", 32'(score_down), 32'd1);
    chk("tmiss_dir_y", 32'(dir_y), 32'd0);
    step_period(2'b00);
    chk("tmiss_idle_pos", 32'(pos_ball), 32'o33);
    chk("tmiss_serve_dir", 32'(dir_y), 32'd0);

    // start during MOVE must not restart the divider
    cyc(1'b1, 2'b00);
    cyc(1'b1, 2'b00);
    cyc(1'b1, 2'b00);
    cyc(1'b0, 2'b00);
    chk("start_ign_hold", 32'(pos_ball), 32'o33);
    cyc(1'b0, 2'b00);
    chk("start_ign_step", 32'(pos_ball), 32'o42);
    rally(1'b0);

    // score saturation
    for (int i = 0; i < 20 && mtop < 15; i++) rally(1'b1);
    chk("sat_reach", 32'(score_top), 32'd15);
    rally(1'b1);
    chk("sat_hold", 32'(score_top), 32'd15);

    // asynchronous reset between edges
    cyc(1'b1, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pos", 32'(pos_ball), 32'o33);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_scores", 32'({score_top, score_down}), 32'd0);
    chk("arst_dirs", 32'({dir_x, dir_y}), 32'd3);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 2'b00);
    for (int i = 0; i < TICK - 1; i++) cyc(1'b0, 2'b00);
    chk("arst_div_hold", 32'(pos_ball), 32'o33);
    cyc(1'b0, 2'b00);
    chk("arst_div_step", 32'(pos_ball), 32'o44);

    // random play
    for (int n = 0; n < 1500; n++) begin
      if (mode != 0 && ticks == TICK - 1) begin
        r = $urandom_range(0, 9);
        if (r < 7 && my == 1 && mdy == 0)      rp = 2'b01;
        else if (r < 7 && my == 6 && mdy == 1) rp = 2'b10;
        else                                   rp = 2'($urandom_range(0, 2));
      end else begin
        rp = 2'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 3) == 0, rp);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
